ysyx_24100005_lsu: RTL and testbench
====================================

YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the byte-address width.
REQ-002 Parameter DATA_W, default 32, SHALL set the memory data width; the only legal values are 32 and 64.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Core request ports SHALL be:
- req_valid, in, 1
- req_ready, out, 1
- req_we, in, 1: 1 = store
- req_funct3, in, 3: RV funct3
- req_addr, in, ADDR_W
- req_wdata, in, DATA_W
REQ-006 Core response ports SHALL be:
- resp_valid, out, 1
- resp_ready, in, 1
- resp_rdata, out, DATA_W: extended load data
- resp_err, out, 1: misaligned or illegal access
REQ-007 Memory request ports SHALL be:
- mem_req_valid, out, 1
- mem_req_ready, in, 1
- mem_we, out, 1
- mem_addr, out, ADDR_W: aligned to DATA_W/8
- mem_wdata, out, DATA_W: lane-shifted
- mem_wmask, out, DATA_W/8
REQ-008 Memory response ports SHALL be:
- mem_resp_valid, in, 1
- mem_resp_ready, out, 1
- mem_rdata, in, DATA_W

Function
REQ-009 The FSM SHALL have states IDLE, REQ, WAIT and RESP.
REQ-010 The FSM SHALL decode its outputs as follows:
- req_ready = 1 only in IDLE
- mem_req_valid = 1 only in REQ
- mem_resp_ready = 1 only in WAIT
- resp_valid = 1 only in RESP
REQ-011 In IDLE, when req_valid=1, the block SHALL capture we, funct3, addr and wdata, then:
- go to RESP with resp_err=1 and resp_rdata=0 on a misaligned or illegal access;
- otherwise go to REQ.
REQ-012 Misaligned SHALL mean: halfword with addr[0]≠0; word with addr[1:0]≠0; doubleword with addr[2:0]≠0.
REQ-013 Illegal SHALL mean: funct3 011 or 110 when DATA_W=32; load funct3 111; store funct3 ≥100.
REQ-014 In REQ, mem_addr, mem_we, mem_wdata and mem_wmask SHALL be driven from the captured request, held stable, with a transition to WAIT on mem_req_ready=1.
REQ-015 In WAIT, on mem_resp_valid=1 the block SHALL latch the extracted load data (stores latch 0) and go to RESP.
REQ-016 In RESP, resp_valid, resp_rdata and resp_err SHALL be held stable until resp_ready=1, then the FSM SHALL return to IDLE.
REQ-017 Load extraction SHALL select the byte lane using addr[log2(DATA_W/8)-1:0], then:
- lb/lh/lw sign-extend;
- lbu/lhu/lwu zero-extend;
- ld passes the data through.
REQ-018 Store mem_wmask SHALL contain 1/2/4/8 contiguous ones shifted by the lane offset, and req_wdata SHALL be shifted into the same lane.
REQ-019 Load mem_wmask SHALL be 0.
REQ-020 A new request SHALL NOT be accepted until the prior response handshake completes (single outstanding transaction).
REQ-021 Minimum latency from acceptance to resp_valid SHALL be 3 cycles for a memory access and 1 cycle for an error.

Reset
REQ-022 While rst=1, the state SHALL be IDLE and every output SHALL be 0, including req_ready.
REQ-023 Reset asserted mid-transaction SHALL immediately drop mem_req_valid, mem_resp_ready and resp_valid.
REQ-024 A memory response arriving after such a reset SHALL be ignored.

Structure
REQ-025 Package ysyx_24100005_lsu_pkg SHALL hold the FSM state enum and the funct3 constants LB, LH, LW, LD, LBU, LHU, LWU.
REQ-026 Combinational lane alignment, mask generation and extension SHALL live in the sub-module ysyx_24100005_lsu_align; the FSM and capture registers SHALL be in ysyx_24100005_lsu.

Verification
REQ-027 Store byte (DATA_W=32): sb, addr 0x8000_0003, wdata 0x0000_00AB -> mem_addr 0x8000_0000, mem_wmask 4'b1000, mem_wdata 0xAB00_0000; response resp_err=0, resp_rdata=0.
REQ-028 Halfword loads: lh, addr 0x8000_0002, mem_rdata 0x8123_4567 -> resp_rdata 0xFFFF_8123. lhu, same stimulus -> 0x0000_8123.
REQ-029 Misaligned load: lw, addr 0x8000_0001 -> resp_valid=1 with resp_err=1 one cycle after acceptance; mem_req_valid never asserted.
REQ-030 Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid, mem_addr and mem_wdata stable throughout. resp_ready low for 3 cycles -> resp_valid and resp_rdata stable.
REQ-031 Reset mid-transaction: rst pulsed in WAIT -> all outputs 0 asynchronously; a mem_resp_valid after reset is ignored. A following lw at 0x8000_0004 with mem_rdata 0x1234_5678 returns 0x1234_5678.
REQ-032 DATA_W=64:
- ld, addr 0x8000_0008, mem_rdata 0x8877_6655_4433_2211 -> resp_rdata unchanged.
- lw at 0x8000_000C, same data -> 0xFFFF_FFFF_8877_6655.
- sd at 0x8000_0004 -> resp_err=1.

Source files
------------

// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV funct3
// encodings and the access legality check applied when a request is accepted.
package ysyx_24100005_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    // funct3[1:0] encodes log2 of the access size for loads and stores alike.
    function automatic logic access_error(
        input logic       we,
        input logic [2:0] funct3,
        input logic [2:0] addr_lo,
        input logic       is_64
    );
        logic misaligned;
        logic illegal;
        case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo[1:0];
            default: misaligned = |addr_lo;
        endcase
        illegal = (!is_64 && (funct3 == LD || funct3 == LWU))
                || (!we && funct3 == 3'b111)
                || (we && funct3[2]);
        return misaligned | illegal;
    endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational byte-lane datapath: store data/mask placement into the memory
// word and load-data extraction with sign or zero extension.
module ysyx_24100005_lsu_align
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int BYTES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(BYTES)
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BYTES-1:0]  mem_wmask,
    output logic [DATA_W-1:0] load_data
);

    logic [OFF_W+2:0]  shamt;
    logic [7:0]        base_mask;
    logic [DATA_W-1:0] lane;

    assign shamt = {offset, 3'b000};

    // NOTE: every output of this block is given a default before the case
    // statements, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        mem_wdata = '0;
        mem_wmask = '0;
        load_data = '0;

        case (funct3[1:0])
            2'b00:   base_mask = 8'h01;
            2'b01:   base_mask = 8'h03;
            2'b10:   base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase

        if (we) begin
            mem_wdata = wdata << shamt;
            mem_wmask = BYTES'(base_mask) << offset;
        end

        // Bring the addressed lane down to bit 0, then extend to full width.
        lane = rdata >> shamt;
        case (funct3)
            LB:      load_data = DATA_W'({{56{lane[7]}},  lane[7:0]});
            LH:      load_data = DATA_W'({{48{lane[15]}}, lane[15:0]});
            LW:      load_data = DATA_W'({{32{lane[31]}}, lane[31:0]});
            LBU:     load_data = DATA_W'({56'd0, lane[7:0]});
            LHU:     load_data = DATA_W'({48'd0, lane[15:0]});
            LWU:     load_data = DATA_W'({32'd0, lane[31:0]});
            default: load_data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: accepts one core request at a time, issues a single aligned
// memory beat, and returns extended load data or an access error.
module ysyx_24100005_lsu
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,

    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,

    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_t state;
    state_t next_state;

    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [DATA_W-1:0] load_data;

    assign accept  = (state == IDLE) && req_valid;
    assign req_err = access_error(req_we, req_funct3, req_addr[2:0], DATA_W == 64);

    // NOTE: state and capture registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_valid)      next_state = req_err ? RESP : REQ;
            REQ:     if (mem_req_ready)  next_state = WAIT;
            WAIT:    if (mem_resp_valid) next_state = RESP;
            RESP:    if (resp_ready)     next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                rdata_q  <= '0;
                err_q    <= req_err;
            end
            // Store responses carry no data, so they latch zero.
            if (state == WAIT && mem_resp_valid) begin
                rdata_q <= we_q ? '0 : load_data;
            end
        end
    end

    ysyx_24100005_lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .we        (we_q),
        .funct3    (funct3_q),
        .offset    (addr_q[OFF_W-1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .load_data (load_data)
    );

    // req_ready is gated by rst so nothing is offered while reset is held.
    assign req_ready      = (state == IDLE) && !rst;
    assign mem_req_valid  = (state == REQ);
    assign mem_resp_ready = (state == WAIT);
    assign resp_valid     = (state == RESP);

    assign mem_we     = we_q;
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu: a 32-bit and a 64-bit instance
// share stimulus, and a byte-arithmetic reference model predicts every result.
module tb_ysyx_24100005_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel64;

    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_ready;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [63:0] mem_rdata;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_mem_req_valid, a_mem_we, a_mem_resp_ready;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [3:0]  a_mem_wmask;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_mem_req_valid, b_mem_we, b_mem_resp_ready;
    logic [63:0] b_resp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [7:0]  b_mem_wmask;

    logic        req_ready_m, resp_valid_m, resp_err_m, mem_req_valid_m, mem_we_m, mem_resp_ready_m;
    logic [63:0] resp_rdata_m, mem_wdata_m;
    logic [31:0] mem_addr_m;
    logic [7:0]  mem_wmask_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid && !sel64),
        .req_ready      (a_req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata[31:0]),
        .resp_valid     (a_resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (a_resp_rdata),
        .resp_err       (a_resp_err),
        .mem_req_valid  (a_mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (a_mem_we),
        .mem_addr       (a_mem_addr),
        .mem_wdata      (a_mem_wdata),
        .mem_wmask      (a_mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (a_mem_resp_ready),
        .mem_rdata      (mem_rdata[31:0])
    );

    ysyx_24100005_lsu #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid && sel64),
        .req_ready      (b_req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (b_resp_valid),
        .resp_ready     (resp_ready),
        .resp_rdata     (b_resp_rdata),
        .resp_err       (b_resp_err),
        .mem_req_valid  (b_mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_we         (b_mem_we),
        .mem_addr       (b_mem_addr),
        .mem_wdata      (b_mem_wdata),
        .mem_wmask      (b_mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (b_mem_resp_ready),
        .mem_rdata      (mem_rdata)
    );

    assign req_ready_m      = sel64 ? b_req_ready      : a_req_ready;
    assign resp_valid_m     = sel64 ? b_resp_valid     : a_resp_valid;
    assign resp_err_m       = sel64 ? b_resp_err       : a_resp_err;
    assign mem_req_valid_m  = sel64 ? b_mem_req_valid  : a_mem_req_valid;
    assign mem_we_m         = sel64 ? b_mem_we         : a_mem_we;
    assign mem_resp_ready_m = sel64 ? b_mem_resp_ready : a_mem_resp_ready;
    assign resp_rdata_m     = sel64 ? b_resp_rdata     : {32'd0, a_resp_rdata};
    assign mem_wdata_m      = sel64 ? b_mem_wdata      : {32'd0, a_mem_wdata};
    assign mem_addr_m       = sel64 ? b_mem_addr       : a_mem_addr;
    assign mem_wmask_m      = sel64 ? b_mem_wmask      : {4'd0, a_mem_wmask};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: access = size bytes at addr inside a word of 'bytes' bytes.
    function automatic void model(
        input  bit          we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [63:0] wdata,
        input  logic [63:0] rdata,
        input  bit          w64,
        output bit          err,
        output logic [63:0] rd,
        output logic [31:0] maddr,
        output logic [7:0]  mask,
        output logic [63:0] mwdata
    );
        int          bytes;
        int          size;
        int          off;
        logic [63:0] dmask;
        logic [63:0] field;
        logic [63:0] v;
        bytes = w64 ? 8 : 4;
        size  = 1 << f3[1:0];
        off   = int'(addr[2:0]) % bytes;
        dmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        err   = (int'(addr[2:0]) % size) != 0;
        if (!w64 && (f3 == 3'd3 || f3 == 3'd6)) err = 1'b1;
        if (!we && f3 == 3'd7) err = 1'b1;
        if (we && f3 >= 3'd4) err = 1'b1;
        maddr  = addr - 32'(off);
        rd     = '0;
        mask   = '0;
        mwdata = '0;
        if (we) begin
            mask   = 8'(((1 << size) - 1) << off);
            mwdata = (wdata << (8 * off)) & dmask;
        end else if (!err) begin
            v = (rdata & dmask) >> (8 * off);
            if (size < 8) begin
                field = (64'd1 << (8 * size)) - 64'd1;
                v = v & field;
                if (!f3[2] && v[8 * size - 1]) v = v | ~field;
            end
            rd = v & dmask;
        end
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " req_ready"},      req_ready_m, 0);
        check({tag, " resp_valid"},     resp_valid_m, 0);
        check({tag, " resp_err"},       resp_err_m, 0);
        check({tag, " resp_rdata"},     resp_rdata_m, 0);
        check({tag, " mem_req_valid"},  mem_req_valid_m, 0);
        check({tag, " mem_we"},         mem_we_m, 0);
        check({tag, " mem_addr"},       mem_addr_m, 0);
        check({tag, " mem_wdata"},      mem_wdata_m, 0);
        check({tag, " mem_wmask"},      mem_wmask_m, 0);
        check({tag, " mem_resp_ready"}, mem_resp_ready_m, 0);
    endtask

    task automatic txn(
        input string       tag,
        input bit          we,
        input logic [2:0]  f3,
        input logic [31:0] addr,
        input logic [63:0] wdata,
        input logic [63:0] rdata,
        input int          req_stall,
        input int          resp_stall
    );
        bit          e;
        logic [63:0] erd;
        logic [63:0] ewd;
        logic [31:0] ea;
        logic [7:0]  em;
        model(we, f3, addr, wdata, rdata, sel64, e, erd, ea, em, ewd);

        @(negedge clk);
        check({tag, " req_ready idle"}, req_ready_m, 1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(negedge clk);
        // Scramble request fields so only captured values can produce a match.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = {$urandom, $urandom};
        check({tag, " req_ready busy"}, req_ready_m, 0);

        if (e) begin
            check({tag, " no mem_req_valid"}, mem_req_valid_m, 0);
            check({tag, " err resp_valid 1cyc"}, resp_valid_m, 1);
        end else begin
            for (int i = 0; i <= req_stall; i++) begin
                check({tag, " mem_req_valid"}, mem_req_valid_m, 1);
                check({tag, " mem_we"},        mem_we_m, we);
                check({tag, " mem_addr"},      mem_addr_m, ea);
                check({tag, " mem_wdata"},     mem_wdata_m, ewd);
                check({tag, " mem_wmask"},     mem_wmask_m, em);
                check({tag, " early resp"},    resp_valid_m, 0);
                if (i == req_stall) mem_req_ready = 1'b1;
                @(negedge clk);
            end
            mem_req_ready = 1'b0;
            check({tag, " mem_req_valid drop"}, mem_req_valid_m, 0);
            check({tag, " mem_resp_ready"},     mem_resp_ready_m, 1);
            check({tag, " resp not yet"},       resp_valid_m, 0);
            mem_rdata      = rdata;
            mem_resp_valid = 1'b1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            mem_rdata      = {$urandom, $urandom};
            check({tag, " resp_valid 3cyc"}, resp_valid_m, 1);
        end

        for (int i = 0; i <= resp_stall; i++) begin
            check({tag, " resp_valid held"}, resp_valid_m, 1);
            check({tag, " resp_err"},        resp_err_m, e);
            check({tag, " resp_rdata"},      resp_rdata_m, erd);
            if (i == resp_stall) resp_ready = 1'b1;
            @(negedge clk);
        end
        resp_ready = 1'b0;
        check({tag, " resp_valid done"}, resp_valid_m, 0);
        check({tag, " back to idle"},    req_ready_m, 1);
    endtask

    task automatic random_txn(input string tag);
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        we   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = 32'h8000_0000 | 32'($urandom_range(0, 255));
        // Bias half of the accesses toward natural alignment.
        if ($urandom_range(0, 1) == 1) addr = addr & ~((32'd1 << f3[1:0]) - 32'd1);
        txn(tag, we, f3, addr, {$urandom, $urandom}, {$urandom, $urandom},
            $urandom_range(0, 2), $urandom_range(0, 2));
    endtask

    initial begin
        rst            = 1'b1;
        sel64          = 1'b0;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_funct3     = '0;
        req_addr       = '0;
        req_wdata      = '0;
        resp_ready     = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;

        #2;
        check_all_zero("reset32");
        sel64 = 1'b1;
        #1;
        check_all_zero("reset64");
        sel64 = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        txn("sb",  1'b1, 3'b000, 32'h8000_0003, 64'h0000_00AB, 64'h0, 0, 0);
        txn("lh",  1'b0, 3'b001, 32'h8000_0002, 64'h0, 64'h8123_4567, 0, 0);
        txn("lhu", 1'b0, 3'b101, 32'h8000_0002, 64'h0, 64'h8123_4567, 0, 0);
        txn("lw_mis", 1'b0, 3'b010, 32'h8000_0001, 64'h0, 64'h0, 0, 0);
        txn("ld_on32", 1'b0, 3'b011, 32'h8000_0000, 64'h0, 64'h0, 0, 0);
        txn("sw_bp", 1'b1, 3'b010, 32'h8000_0008, 64'hCAFE_BABE, 64'h0, 5, 3);
        txn("lb_bp", 1'b0, 3'b000, 32'h8000_0001, 64'h0, 64'h0000_8000, 5, 3);

        // Reset while waiting for the memory response.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h8000_0000;
        @(negedge clk);
        req_valid     = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        check("rst_mid in WAIT", mem_resp_ready_m, 1);
        #2 rst = 1'b1;
        #1;
        check_all_zero("rst_mid async");
        @(negedge clk);
        rst            = 1'b0;
        mem_rdata      = 64'hDEAD_BEEF;
        mem_resp_valid = 1'b1;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("stale resp_valid",    resp_valid_m, 0);
        check("stale resp_rdata",    resp_rdata_m, 0);
        check("stale req_ready",     req_ready_m, 1);
        check("stale mem_resp_rdy",  mem_resp_ready_m, 0);
        txn("lw_after_rst", 1'b0, 3'b010, 32'h8000_0004, 64'h0, 64'h1234_5678, 0, 0);

        for (int i = 0; i < 40; i++) random_txn("rand32");

        sel64 = 1'b1;
        txn("ld64",    1'b0, 3'b011, 32'h8000_0008, 64'h0, 64'h8877_6655_4433_2211, 0, 0);
        txn("lw64",    1'b0, 3'b010, 32'h8000_000C, 64'h0, 64'h8877_6655_4433_2211, 0, 0);
        txn("lwu64",   1'b0, 3'b110, 32'h8000_000C, 64'h0, 64'h8877_6655_4433_2211, 0, 0);
        txn("sd64_mis", 1'b1, 3'b011, 32'h8000_0004, 64'h1122_3344_5566_7788, 64'h0, 0, 0);
        txn("sh64",    1'b1, 3'b001, 32'h8000_0006, 64'h0000_0000_0000_BEEF, 64'h0, 1, 1);
        for (int i = 0; i < 25; i++) random_txn("rand64");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
